frame_line_fetch: RTL and testbench

- Upstream feeder for the line-to-pixel read FIFO in the optical-flow read path.
- On start, issues sequential line-wide reads of one frame region to a memory read port and collects in-order responses in a small credit-managed response buffer.
- Pushes the buffered lines into the read FIFO's write side (line_in/we/full).
- Never writes while the FIFO reports full, because the FIFO advances its head pointer on every we.

---
 rtl/frame_fetch_pkg.sv | 18 +
 rtl/fetch_rsp_buf.sv | 63 ++++++
 rtl/frame_line_fetch.sv | 174 +++++++++++++++++
 tb/tb_frame_line_fetch.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_fetch_pkg.sv
// Shared types and sizing helpers for the frame line fetcher and its response buffer.
package frame_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  localparam int DEF_LINE_WIDTH      = 32;
  localparam int DEF_MAX_OUTSTANDING = 4;

  // A credit counter must be able to hold the full depth itself, not just depth-1.
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_rsp_buf.sv
// Small in-order response buffer: synchronous FIFO with push/pop/count and a
// combinational head so a buffered line can leave in the cycle after it arrives.
module fetch_rsp_buf
  import frame_fetch_pkg::*;
#(
  parameter int  WIDTH = DEF_LINE_WIDTH,
  parameter int  DEPTH = DEF_MAX_OUTSTANDING,
  localparam int CW    = credit_width(DEPTH),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [CW-1:0]    o_count,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!w_full || w_pop);
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      // NOTE: storage is reset as well; it is only DEPTH entries and keeps the head output defined.
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_clr) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // The fetcher's credit rule must never let a response arrive with no room for it.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && w_full && !w_pop && !i_clr));

endmodule

// File: rtl/frame_line_fetch.sv
// Issues sequential line reads for one frame region, buffers the in-order responses
// and feeds them to the line FIFO write side without ever writing into a full FIFO.
module frame_line_fetch
  import frame_fetch_pkg::*;
#(
  parameter int LINE_WIDTH      = DEF_LINE_WIDTH,
  parameter int ADDR_WIDTH      = 32,
  parameter int CNT_WIDTH       = 20,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int ADDR_STRIDE     = LINE_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_lines,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  output logic [LINE_WIDTH-1:0] fifo_line,
  output logic                  fifo_we,
  input  logic                  fifo_full
);

  localparam int CW = credit_width(MAX_OUTSTANDING);
  localparam int SW = CW + 1;
  localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(ADDR_STRIDE);

  fetch_state_e          r_state;
  logic [ADDR_WIDTH-1:0] r_next_addr;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [CNT_WIDTH-1:0]  r_num;
  logic [CNT_WIDTH-1:0]  r_req_cnt;
  logic [CNT_WIDTH-1:0]  r_wr_cnt;
  logic [CW-1:0]         r_outstanding;
  logic                  r_mem_req;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_aborted;

  logic                  w_fetch;
  logic                  w_grant;
  logic                  w_hold;
  logic                  w_rsp;
  logic                  w_push;
  logic                  w_we;
  logic                  w_last_we;
  logic                  w_issue;
  logic                  w_credit_ok;
  logic [CW-1:0]         w_buf_count;
  logic                  w_buf_empty;
  logic [LINE_WIDTH-1:0] w_buf_head;
  logic [CW-1:0]         w_out_nxt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [CNT_WIDTH-1:0]  w_req_cnt_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;

  assign w_fetch   = (r_state == ST_FETCH);
  assign w_grant   = r_mem_req && mem_gnt;
  assign w_hold    = r_mem_req && !mem_gnt;
  // Responses count only against lines actually in flight; strays are dropped.
  assign w_rsp     = mem_rvalid && (r_outstanding != '0) && (r_state != ST_IDLE);
  assign w_push    = w_rsp && w_fetch;
  assign w_we      = w_fetch && !w_buf_empty && !fifo_full;
  assign w_last_we = w_we && ((r_wr_cnt + CNT_WIDTH'(1)) == r_num);

  assign w_out_nxt     = r_outstanding + CW'(w_grant) - CW'(w_rsp);
  assign w_cnt_nxt     = w_buf_count + CW'(w_push) - CW'(w_we);
  assign w_req_cnt_nxt = r_req_cnt + CNT_WIDTH'(w_grant);
  assign w_addr_nxt    = w_grant ? (r_next_addr + STRIDE) : r_next_addr;

  // The next request is decided on post-edge occupancy so a grant can be followed
  // immediately by another request when credit remains.
  assign w_credit_ok = (SW'(w_out_nxt) + SW'(w_cnt_nxt)) < SW'(MAX_OUTSTANDING);
  assign w_issue     = w_fetch && !abort && (w_req_cnt_nxt < r_num) && w_credit_ok;

  fetch_rsp_buf #(
    .WIDTH (LINE_WIDTH),
    .DEPTH (MAX_OUTSTANDING)
  ) u_rsp_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (r_state == ST_FLUSH),
    .i_push  (w_push),
    .i_data  (mem_rdata),
    .i_pop   (w_we),
    .o_head  (w_buf_head),
    .o_count (w_buf_count),
    .o_empty (w_buf_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_next_addr   <= '0;
      r_mem_addr    <= '0;
      r_num         <= '0;
      r_req_cnt     <= '0;
      r_wr_cnt      <= '0;
      r_outstanding <= '0;
      r_mem_req     <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_aborted     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_aborted <= 1'b0;
            if (num_lines == '0) begin
              r_done <= 1'b1;
            end else begin
              r_state       <= ST_FETCH;
              r_busy        <= 1'b1;
              r_num         <= num_lines;
              r_next_addr   <= base_addr;
              r_req_cnt     <= '0;
              r_wr_cnt      <= '0;
              r_outstanding <= '0;
            end
          end
        end

        ST_FETCH: begin
          r_req_cnt     <= w_req_cnt_nxt;
          r_next_addr   <= w_addr_nxt;
          r_outstanding <= w_out_nxt;
          if (w_we) r_wr_cnt <= r_wr_cnt + CNT_WIDTH'(1);
          // An ungranted request keeps its valid and address untouched.
          if (!w_hold) begin
            r_mem_req <= w_issue;
            if (w_issue) r_mem_addr <= w_addr_nxt;
          end
          if (w_last_we) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (abort) begin
            r_state <= ST_FLUSH;
          end
        end

        ST_FLUSH: begin
          r_outstanding <= w_out_nxt;
          r_mem_req     <= w_hold;
          if (!w_hold && (w_out_nxt == '0)) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_aborted <= 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign aborted   = r_aborted;
  assign mem_req   = r_mem_req;
  assign mem_addr  = r_mem_addr;
  assign fifo_we   = w_we;
  assign fifo_line = w_buf_head;

endmodule

// File: tb/tb_frame_line_fetch.sv
// Directed bench for frame_line_fetch: a 3-cycle-latency memory model, a FIFO-full
// control and a write log compared against hand-computed addresses and line data.
module tb_frame_line_fetch;

  localparam int LW = 32;
  localparam int AW = 32;
  localparam int NW = 20;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [NW-1:0] num_lines = '0;
  logic          busy, done, aborted, mem_req, fifo_we;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [LW-1:0] mem_rdata = '0;
  logic [LW-1:0] fifo_line;
  logic          fifo_full = 1'b0;

  int checks = 0;
  int failures = 0;

  // Stimulus controls read by the memory/FIFO side process.
  logic gnt_ctl = 1'b1;
  logic full_ctl = 1'b0;
  logic rv_force = 1'b0;
  int   stall_at = -1;
  int   stall_left = 0;

  // Observations collected by the monitor.
  int cyc = 0;
  int grants = 0;
  int rvalids = 0;
  int done_cnt = 0;
  int hold_err = 0;
  int full_we_err = 0;
  int last_we_cyc = -1;
  int last_rv_cyc = -1;
  int done_cyc = -1;
  logic done_busy = 1'b0;
  logic [AW-1:0] addr_log[$];
  logic [LW-1:0] we_log[$];

  frame_line_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .base_addr  (base_addr),
    .num_lines  (num_lines),
    .busy       (busy),
    .done       (done),
    .aborted    (aborted),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .fifo_line  (fifo_line),
    .fifo_we    (fifo_we),
    .fifo_full  (fifo_full)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] mem_model(input logic [AW-1:0] a);
    return {~a[15:0], a[15:0]} ^ {a[31:16], 16'h0};
  endfunction

  function automatic logic [AW-1:0] line_addr(input logic [AW-1:0] base, input int i);
    return base + AW'(4 * i);
  endfunction

  // Monitor at negedge, drive memory/FIFO inputs 1 time unit after posedge.
  initial begin : mem_side
    logic          p0_v, p1_v, gnt_seen, prev_hold, prev_rst;
    logic [LW-1:0] p0_d, p1_d, gnt_data;
    logic [AW-1:0] prev_addr;
    p0_v = 1'b0; p1_v = 1'b0; p0_d = '0; p1_d = '0;
    gnt_data = '0; prev_hold = 1'b0; prev_rst = 1'b0; prev_addr = '0;
    forever begin
      @(negedge clk);
      cyc++;
      gnt_seen = 1'b0;
      if (rst_n && prev_rst && prev_hold && (mem_req !== 1'b1 || mem_addr !== prev_addr))
        hold_err++;
      prev_hold = rst_n && mem_req && !mem_gnt;
      prev_addr = mem_addr;
      prev_rst  = rst_n;
      if (rst_n && mem_req && mem_gnt) begin
        grants++;
        addr_log.push_back(mem_addr);
        gnt_seen = 1'b1;
        gnt_data = mem_model(mem_addr);
      end
      if (mem_rvalid) begin
        rvalids++;
        last_rv_cyc = cyc;
      end
      if (fifo_we) begin
        we_log.push_back(fifo_line);
        last_we_cyc = cyc;
        if (fifo_full) full_we_err++;
      end
      if (done) begin
        done_cnt++;
        done_cyc  = cyc;
        done_busy = busy;
      end
      @(posedge clk);
      #1;
      mem_rvalid = p1_v || rv_force;
      mem_rdata  = p1_v ? p1_d : 32'hBAD0_BAD0;
      p1_v = p0_v;  p1_d = p0_d;
      p0_v = gnt_seen; p0_d = gnt_data;
      if (stall_left > 0 && grants == stall_at) begin
        mem_gnt = 1'b0;
        stall_left--;
      end else begin
        mem_gnt = gnt_ctl;
      end
      fifo_full = full_ctl;
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic clear_logs();
    grants = 0; rvalids = 0; done_cnt = 0; hold_err = 0; full_we_err = 0;
    last_we_cyc = -1; last_rv_cyc = -1; done_cyc = -1;
    addr_log.delete();
    we_log.delete();
  endtask

  task automatic start_xfer(input logic [AW-1:0] base, input logic [NW-1:0] n);
    base_addr = base;
    num_lines = n;
    start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      cycles(1);
      n++;
    end
    checks++;
    if (done_cnt == 0) begin
      failures++;
      $display("FAIL %s_done_timeout: done not seen in %0d cycles", name, budget);
    end
  endtask

  task automatic wait_grants(input int target, input int budget, input string name);
    int n = 0;
    while (grants < target && n < budget) begin
      cycles(1);
      n++;
    end
    checks++;
    if (grants < target) begin
      failures++;
      $display("FAIL %s_grant_timeout: grants=%0d expected>=%0d", name, grants, target);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycles(2);
    checks++; if (busy !== 1'b0)    begin failures++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (done !== 1'b0)    begin failures++; $display("FAIL reset_done: got %b exp 0", done); end
    checks++; if (aborted !== 1'b0) begin failures++; $display("FAIL reset_aborted: got %b exp 0", aborted); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req: got %b exp 0", mem_req); end
    checks++; if (fifo_we !== 1'b0) begin failures++; $display("FAIL reset_fifo_we: got %b exp 0", fifo_we); end
    checks++; if (mem_addr !== '0)  begin failures++; $display("FAIL reset_mem_addr: got %h exp 0", mem_addr); end
    rst_n = 1'b1;
    cycles(2);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b exp 0", busy); end
  endtask

  task automatic test_basic();
    clear_logs();
    gnt_ctl = 1'b1; full_ctl = 1'b0;
    start_xfer(32'h0000_1000, 4);
    wait_done(60, "basic");
    checks++;
    if (addr_log.size() != 4) begin failures++; $display("FAIL basic_grants: got %0d exp 4", addr_log.size()); end
    for (int i = 0; i < addr_log.size() && i < 4; i++) begin
      checks++;
      if (addr_log[i] !== line_addr(32'h1000, i)) begin
        failures++; $display("FAIL basic_addr[%0d]: got %h exp %h", i, addr_log[i], line_addr(32'h1000, i));
      end
    end
    checks++;
    if (we_log.size() != 4) begin failures++; $display("FAIL basic_we_count: got %0d exp 4", we_log.size()); end
    for (int i = 0; i < we_log.size() && i < 4; i++) begin
      checks++;
      if (we_log[i] !== mem_model(line_addr(32'h1000, i))) begin
        failures++; $display("FAIL basic_line[%0d]: got %h exp %h", i, we_log[i], mem_model(line_addr(32'h1000, i)));
      end
    end
    checks++;
    if (done_cyc != last_we_cyc + 1) begin
      failures++; $display("FAIL basic_done_latency: done cyc %0d last we cyc %0d", done_cyc, last_we_cyc);
    end
    checks++; if (done_busy !== 1'b0) begin failures++; $display("FAIL basic_busy_at_done: got %b exp 0", done_busy); end
    cycles(3);
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL basic_done_pulses: got %0d exp 1", done_cnt); end
    checks++; if (aborted !== 1'b0) begin failures++; $display("FAIL basic_aborted: got %b exp 0", aborted); end
  endtask

  task automatic test_backpressure();
    clear_logs();
    gnt_ctl = 1'b1; full_ctl = 1'b1;
    start_xfer(32'h0000_2000, 10);
    cycles(20);
    checks++; if (grants != 4) begin failures++; $display("FAIL bp_grants_while_full: got %0d exp 4", grants); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL bp_mem_req_while_full: got %b exp 0", mem_req); end
    checks++; if (we_log.size() != 0) begin failures++; $display("FAIL bp_we_while_full: got %0d writes exp 0", we_log.size()); end
    full_ctl = 1'b0;
    wait_done(200, "bp");
    checks++; if (full_we_err != 0) begin failures++; $display("FAIL bp_we_during_full: got %0d exp 0", full_we_err); end
    checks++; if (we_log.size() != 10) begin failures++; $display("FAIL bp_we_count: got %0d exp 10", we_log.size()); end
    for (int i = 0; i < we_log.size() && i < 10; i++) begin
      checks++;
      if (we_log[i] !== mem_model(line_addr(32'h2000, i))) begin
        failures++; $display("FAIL bp_line[%0d]: got %h exp %h", i, we_log[i], mem_model(line_addr(32'h2000, i)));
      end
    end
  endtask

  task automatic test_gnt_stall();
    clear_logs();
    gnt_ctl = 1'b1; full_ctl = 1'b0;
    stall_at = 1; stall_left = 5;
    start_xfer(32'h0000_1000, 10);
    wait_grants(1, 20, "stall");
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h0000_1004) begin
        failures++; $display("FAIL stall_hold[%0d]: req=%b addr=%h exp req=1 addr=00001004", i, mem_req, mem_addr);
      end
      cycles(1);
    end
    wait_done(200, "stall");
    stall_at = -1;
    checks++; if (grants != 10) begin failures++; $display("FAIL stall_grants: got %0d exp 10", grants); end
    checks++; if (hold_err != 0) begin failures++; $display("FAIL stall_req_stability: got %0d violations exp 0", hold_err); end
    for (int i = 0; i < we_log.size() && i < 10; i++) begin
      checks++;
      if (we_log[i] !== mem_model(line_addr(32'h1000, i))) begin
        failures++; $display("FAIL stall_line[%0d]: got %h exp %h", i, we_log[i], mem_model(line_addr(32'h1000, i)));
      end
    end
  endtask

  task automatic test_abort();
    clear_logs();
    gnt_ctl = 1'b1; full_ctl = 1'b0;
    start_xfer(32'h0000_3000, 10);
    wait_grants(2, 20, "abort");
    abort = 1'b1;
    wait_done(100, "abort");
    abort = 1'b0;
    checks++; if (grants != 3) begin failures++; $display("FAIL abort_grants: got %0d exp 3", grants); end
    checks++; if (we_log.size() != 0) begin failures++; $display("FAIL abort_we: got %0d writes exp 0", we_log.size()); end
    checks++; if (rvalids != 3) begin failures++; $display("FAIL abort_rvalids: got %0d exp 3", rvalids); end
    checks++;
    if (done_cyc != last_rv_cyc + 1) begin
      failures++; $display("FAIL abort_done_timing: done cyc %0d last rvalid cyc %0d", done_cyc, last_rv_cyc);
    end
    checks++; if (aborted !== 1'b1) begin failures++; $display("FAIL abort_flag: got %b exp 1", aborted); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b exp 0", busy); end
    checks++; if (hold_err != 0) begin failures++; $display("FAIL abort_req_stability: got %0d exp 0", hold_err); end
    cycles(2);
    clear_logs();
    start_xfer(32'h0000_1000, 1);
    checks++; if (aborted !== 1'b0) begin failures++; $display("FAIL abort_clear_on_start: got %b exp 0", aborted); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL abort_restart_busy: got %b exp 1", busy); end
    wait_done(40, "abort_restart");
    checks++;
    if (we_log.size() != 1 || we_log[0] !== mem_model(32'h1000)) begin
      failures++; $display("FAIL abort_restart_line: count %0d exp 1, line exp %h", we_log.size(), mem_model(32'h1000));
    end
  endtask

  task automatic test_wrap();
    clear_logs();
    gnt_ctl = 1'b1; full_ctl = 1'b0;
    start_xfer(32'hFFFF_FFFC, 2);
    wait_done(40, "wrap");
    checks++; if (addr_log.size() != 2) begin failures++; $display("FAIL wrap_grants: got %0d exp 2", addr_log.size()); end
    if (addr_log.size() == 2) begin
      checks++; if (addr_log[0] !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr0: got %h exp fffffffc", addr_log[0]); end
      checks++; if (addr_log[1] !== 32'h0000_0000) begin failures++; $display("FAIL wrap_addr1: got %h exp 00000000", addr_log[1]); end
    end
    checks++;
    if (we_log.size() != 2) begin failures++; $display("FAIL wrap_we_count: got %0d exp 2", we_log.size()); end
    else begin
      checks++; if (we_log[0] !== mem_model(32'hFFFF_FFFC)) begin failures++; $display("FAIL wrap_line0: got %h exp %h", we_log[0], mem_model(32'hFFFF_FFFC)); end
      checks++; if (we_log[1] !== mem_model(32'h0))          begin failures++; $display("FAIL wrap_line1: got %h exp %h", we_log[1], mem_model(32'h0)); end
    end
  endtask

  task automatic test_zero_len();
    clear_logs();
    start_xfer(32'h0000_1000, 0);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL zero_done: got %b exp 1", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy: got %b exp 0", busy); end
    cycles(5);
    checks++; if (grants != 0)   begin failures++; $display("FAIL zero_grants: got %0d exp 0", grants); end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL zero_done_pulses: got %0d exp 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    gnt_ctl = 1'b1; full_ctl = 1'b0;
    start_xfer(32'h0000_1000, 10);
    wait_grants(2, 20, "rstmid");
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || fifo_we !== 1'b0 || done !== 1'b0 || mem_addr !== '0) begin
      failures++;
      $display("FAIL rstmid_outputs: busy=%b req=%b we=%b done=%b addr=%h exp all 0", busy, mem_req, fifo_we, done, mem_addr);
    end
    rv_force = 1'b1;
    cycles(2);
    rst_n = 1'b1;
    cycles(3);
    rv_force = 1'b0;
    cycles(4);
    checks++; if (we_log.size() != 0) begin failures++; $display("FAIL rstmid_stray_we: got %0d writes exp 0", we_log.size()); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b exp 0", busy); end
    clear_logs();
    start_xfer(32'h0000_5000, 3);
    wait_done(60, "rstmid_after");
    checks++; if (we_log.size() != 3) begin failures++; $display("FAIL rstmid_after_count: got %0d exp 3", we_log.size()); end
    for (int i = 0; i < we_log.size() && i < 3; i++) begin
      checks++;
      if (we_log[i] !== mem_model(line_addr(32'h5000, i))) begin
        failures++; $display("FAIL rstmid_after_line[%0d]: got %h exp %h", i, we_log[i], mem_model(line_addr(32'h5000, i)));
      end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    test_reset();
    test_basic();
    test_backpressure();
    test_gnt_stall();
    test_abort();
    test_wrap();
    test_zero_len();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
